// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 Hz timing constants shared by the sync generator and its users.
`timescale 1ns/1ps
package vga_timing_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Width of the hpos/vpos counters; totals must fit in it.
  localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/vga_hvsync_generator.sv
// Free-running VGA timing generator: pixel/line counters, active-low syncs and
// a display-enable flag. Syncs are registered from next-state counters so they
// line up with hpos/vpos on the same cycle.
`timescale 1ns/1ps
module vga_hvsync_generator #(
  parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int unsigned W = vga_timing_pkg::CNT_W;

  // Totals must stay at or below 1024 so the 10-bit counters never overflow.
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [W-1:0] H_LAST   = W'(H_TOTAL - 1);
  localparam logic [W-1:0] V_LAST   = W'(V_TOTAL - 1);
  localparam logic [W-1:0] H_VIS    = W'(H_DISPLAY);
  localparam logic [W-1:0] V_VIS    = W'(V_DISPLAY);
  localparam logic [W-1:0] HS_START = W'(H_DISPLAY + H_FRONT);
  localparam logic [W-1:0] HS_END   = W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [W-1:0] VS_START = W'(V_DISPLAY + V_FRONT);
  localparam logic [W-1:0] VS_END   = W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [W-1:0] hpos_q, hpos_d;
  logic [W-1:0] vpos_q, vpos_d;
  logic         hsync_q, hsync_d;
  logic         vsync_q, vsync_d;
  logic         line_end;

  // Next-state counters and syncs derived from the next-state counters.
  always_comb begin
    line_end = (hpos_q == H_LAST);
    hpos_d   = line_end ? '0 : hpos_q + 1'b1;
    vpos_d   = vpos_q;
    if (line_end) begin
      vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
    end
    hsync_d = !((hpos_d >= HS_START) && (hpos_d <= HS_END));
    vsync_d = !((vpos_d >= VS_START) && (vpos_d <= VS_END));
  end

  // Counter and sync state; async reset parks at frame start with syncs idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Scoreboard bench: a full-size 640x480 instance for line-level timing and a
// shrunken instance so several whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_hvsync_generator;

  // Small instance geometry: 15 clocks/line, 13 lines/frame.
  localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VD = 6, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = 15, S_VT = 13, S_FRAME = 195;
  localparam int RUN_CYCLES = 1900;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hs_f, vs_f, de_f, hs_s, vs_s, de_s;
  logic [9:0] hp_f, vp_f, hp_s, vp_s;

  obs_t q_full[$];
  obs_t q_small[$];
  int   n_tests = 0;
  int   n_fail = 0;

  int h_f, v_f, h_s, v_s;
  int hs_low_cnt, last_frame, act_cnt, vs_low_cnt, line_checks;

  always #20 clk = ~clk;

  vga_hvsync_generator dut_full (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsync     (hs_f),
    .vsync     (vs_f),
    .display_on(de_f),
    .hpos      (hp_f),
    .vpos      (vp_f)
  );

  vga_hvsync_generator #(
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .hsync     (hs_s),
    .vsync     (vs_s),
    .display_on(de_s),
    .hpos      (hp_s),
    .vpos      (vp_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", tag, got, got, exp);
    end
  endtask

  function automatic obs_t model_out(int h, int v, int hd, int hss, int hse,
                                     int vd, int vss, int vse);
    obs_t o;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = !(h >= hss && h <= hse);
    o.vs = !(v >= vss && v <= vse);
    o.de = (h < hd) && (v < vd);
    return o;
  endfunction

  function automatic obs_t exp_full(int h, int v);
    return model_out(h, v, 640, 656, 751, 480, 490, 491);
  endfunction

  function automatic obs_t exp_small(int h, int v);
    return model_out(h, v, S_HD, S_HD + S_HF, S_HD + S_HF + S_HS - 1,
                     S_VD, S_VD + S_VF, S_VD + S_VF + S_VS - 1);
  endfunction

  task automatic model_step(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  task automatic compare_obs(input string who, input obs_t got, input obs_t exp);
    check({who, ".hpos"}, 32'(got.h), 32'(exp.h));
    check({who, ".vpos"}, 32'(got.v), 32'(exp.v));
    check({who, ".hsync"}, 32'(got.hs), 32'(exp.hs));
    check({who, ".vsync"}, 32'(got.vs), 32'(exp.vs));
    check({who, ".display_on"}, 32'(got.de), 32'(exp.de));
  endtask

  // Pop the oldest expectations and compare with what both DUTs show now.
  task automatic observe(input int cycle);
    obs_t gf, gs, ef, es;
    gf = {hp_f, vp_f, hs_f, vs_f, de_f};
    gs = {hp_s, vp_s, hs_s, vs_s, de_s};
    if (q_full.size() == 0 || q_small.size() == 0) begin
      check("scoreboard_empty", 32'(q_full.size() + q_small.size()), 32'd2);
      return;
    end
    ef = q_full.pop_front();
    es = q_small.pop_front();
    compare_obs("full", gf, ef);
    compare_obs("small", gs, es);

    // Low hsync clocks per full-size line, checked at each line start.
    if (cycle > 0 && gf.h == 10'd0) begin
      check("full.hsync_low_per_line", 32'(hs_low_cnt), 32'd96);
      hs_low_cnt = 0;
      line_checks++;
    end
    if (gf.hs == 1'b0) hs_low_cnt++;

    // Frame length, active area and vsync width on the small instance.
    if (gs.h == 10'd0 && gs.v == 10'd0) begin
      if (last_frame >= 0) begin
        check("small.frame_len", 32'(cycle - last_frame), 32'(S_FRAME));
        check("small.active_per_frame", 32'(act_cnt), 32'(S_HD * S_VD));
        check("small.vsync_low_per_frame", 32'(vs_low_cnt), 32'(S_VS * S_HT));
      end
      last_frame = cycle;
      act_cnt    = 0;
      vs_low_cnt = 0;
    end
    if (gs.de == 1'b1) act_cnt++;
    if (gs.vs == 1'b0) vs_low_cnt++;
  endtask

  task automatic push_expected();
    q_full.push_back(exp_full(h_f, v_f));
    q_small.push_back(exp_small(h_s, v_s));
  endtask

  initial begin
    hs_low_cnt  = 0;
    act_cnt     = 0;
    vs_low_cnt  = 0;
    last_frame  = -1;
    line_checks = 0;
    h_f = 0; v_f = 0; h_s = 0; v_s = 0;

    // Reset held for 5 clocks: frame start, syncs idle, display_on high.
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    push_expected();
    observe(0);
    rst_n = 1'b1;

    for (int cyc = 1; cyc <= RUN_CYCLES; cyc++) begin
      @(posedge clk);
      model_step(h_f, v_f, 800, 525);
      model_step(h_s, v_s, S_HT, S_VT);
      push_expected();
      @(negedge clk);
      observe(cyc);
    end
    check("full.line_checks_seen", 32'(line_checks), 32'd2);
    check("full.mid_line_hpos", 32'(hp_f), 32'd300);

    // Mid-line asynchronous reset must act without waiting for a clock edge.
    #5 rst_n = 1'b0;
    #1;
    compare_obs("full_async_rst", {hp_f, vp_f, hs_f, vs_f, de_f}, exp_full(0, 0));
    compare_obs("small_async_rst", {hp_s, vp_s, hs_s, vs_s, de_s}, exp_small(0, 0));
    @(negedge clk);
    compare_obs("full_rst_hold", {hp_f, vp_f, hs_f, vs_f, de_f}, exp_full(0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    compare_obs("full_restart", {hp_f, vp_f, hs_f, vs_f, de_f}, exp_full(1, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_hvsync_generator.md
Name: vga_hvsync_generator

Overview:
- VGA 640x480@60 Hz timing generator, one pixel per clk (nominal 25.175 MHz; 25.0 MHz acceptable).
- Produces free-running horizontal/vertical pixel counters, active-low sync pulses and a display-enable flag.
- Sits at the front of the video pipeline; pixel renderers and per-line/per-frame logic key off hpos/vpos.
  - hpos==0 marks line start; hpos==0 && vpos==0 marks frame start.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- display_on  out  1  high while (hpos,vpos) is in the visible area
- hpos  out  10  horizontal pixel counter, 0..H_TOTAL-1
- vpos  out  10  vertical line counter, 0..V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800
  - V_TOTAL = 525
  - H_SYNC_START = H_DISPLAY+H_FRONT = 656; H_SYNC_END = H_SYNC_START+H_SYNC-1 = 751
  - V_SYNC_START = 490; V_SYNC_END = 491
- Reset (rst_n low, asynchronous): hpos=0, vpos=0, hsync=1, vsync=1.
  - Counting starts on the first rising clk after rst_n deasserts.
  - Reset asserted mid-frame immediately forces these values.
- hpos (register):
  - increments by 1 every clk;
  - at H_TOTAL-1 (799), next value is 0 (line wrap).
- vpos (register):
  - changes only on a line wrap;
  - on wrap it increments, except at V_TOTAL-1 (524) where it returns to 0 (frame wrap).
  - Simultaneous hpos=799 and vpos=524 -> next state is (0,0).
- hsync (register):
  - computed from the next-state hpos, so it is aligned with the hpos output (zero relative latency);
  - hsync=0 exactly when hpos is in 656..751, else 1.
- vsync (register): same scheme; vsync=0 exactly when vpos is in 490..491 (for all hpos of those lines), else 1.
- display_on (combinational from hpos/vpos registers): 1 iff hpos<640 && vpos<480.
  - Downstream blanks RGB when it is 0.
- All outputs are glitch-free (driven from registers or a simple compare of registers). No inputs besides clk and rst_n; no handshake.
- Counter widths: 10 bits. Parameter values must keep H_TOTAL and V_TOTAL at or below 1024.

Decomposition:
- Shared package vga_timing_pkg: the eight timing constants plus the derived H_TOTAL, V_TOTAL, H/V_SYNC_START/END.
  - Module parameters default from these constants.
- No sub-module needed. Single module with two counters, two sync registers and one compare.

Test Plan:
- Reset: hold rst_n=0 for 5 clk -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=1. Assert rst_n=0 mid-line (hpos=300, vpos=100) -> outputs return to these values immediately, without waiting for clk.
- Line wrap: after release, count clks -> hpos reaches 799, then 0 on the next clk while vpos goes 0->1; hpos never exceeds 799.
- hsync window, over one line:
  - hsync=1 at hpos 655, 0 at hpos 656 through 751, 1 at hpos 752;
  - exactly 96 low clocks per line.
- vsync/frame:
  - vsync=0 exactly for vpos 490 and 491 (1600 clocks);
  - (799,524) is followed by (0,0);
  - frame length is 420000 clocks between successive (0,0).
- display_on boundaries:
  - 1 at (639,479);
  - 0 at (640,0), (0,480) and (799,524);
  - exactly 307200 active clocks per frame.
- Long run of 3 frames: hpos/vpos follow the expected counter sequence every clk; no X on any output after reset.
